// File: rtl/umi_arbiter_sched_if.sv
// Request/grant bundle between the UMI requesters and the shared-output arbiter.
interface umi_arbiter_sched_if #(
    parameter int unsigned N = 4
) ();
    logic [N-1:0] requests;
    logic         ready;
    logic [N-1:0] grants;

    modport master (output requests, output ready, input grants);
    modport slave  (input requests, input ready, output grants);
endinterface

// File: rtl/umi_arbiter_sched.sv
// UMI output arbiter: fixed-priority / round-robin with grant lock while the sink stalls.
// Optional starvation override compiled in with UMI_ARB_STARVE_EN.
module umi_arbiter_sched #(
    parameter int unsigned N      = 4,
    parameter int unsigned STARVE = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [1:0]           arbmode,
    input  logic [N-1:0]         arbmask,
    umi_arbiter_sched_if.slave   bus
);
    localparam int unsigned PW = 4;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = 8;

    if (N < 2 || N > 16) begin : g_bad_n
        $error("umi_arbiter_sched: N out of range");
    end
    if (STARVE < 1 || STARVE > 255) begin : g_bad_starve
        $error("umi_arbiter_sched: STARVE out of range");
    end

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] held_q, held_d;
    logic [PW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  elig;
    logic [N-1:0]  grants_c;
    logic          win_vld;
    logic [IW-1:0] win_idx;

`ifdef UMI_ARB_STARVE_EN
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic          stv_vld;
    logic [IW-1:0] stv_idx;
`endif

    // Pick the IDLE-state winner among unmasked requesters.
    always_comb begin
        elig    = bus.requests & ~arbmask;
        win_vld = 1'b0;
        win_idx = '0;
        if (arbmode[0]) begin
            // Descending scan so the nearest index at or after the pointer wins last.
            for (int k = N - 1; k >= 0; k--) begin
                if (elig[IW'((32'(ptr_q) + 32'(k)) % N)]) begin
                    win_vld = 1'b1;
                    win_idx = IW'((32'(ptr_q) + 32'(k)) % N);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    win_vld = 1'b1;
                    win_idx = IW'(i);
                end
            end
        end
`ifdef UMI_ARB_STARVE_EN
        stv_vld = 1'b0;
        stv_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[i] && cnt_q[i] == CW'(STARVE)) begin
                stv_vld = 1'b1;
                stv_idx = IW'(i);
            end
        end
        if (stv_vld) begin
            win_vld = 1'b1;
            win_idx = stv_idx;
        end
`endif
    end

    // Grant vector: held requester while locked, otherwise the fresh winner.
    always_comb begin
        grants_c = '0;
        if (state_q == LOCKED) begin
            grants_c[held_q] = bus.requests[held_q];
        end else if (win_vld) begin
            grants_c[win_idx] = 1'b1;
        end
        if (!nreset) begin
            grants_c = '0;
        end
    end

    assign bus.grants = grants_c;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    if (bus.ready) begin
                        ptr_d = PW'((32'(win_idx) + 32'd1) % N);
                    end else begin
                        state_d = LOCKED;
                        held_d  = win_idx;
                    end
                end
            end
            LOCKED: begin
                // A dropped request abandons the lock without advancing the pointer.
                if (!bus.requests[held_q]) begin
                    state_d = IDLE;
                end else if (bus.ready) begin
                    state_d = IDLE;
                    ptr_d   = PW'((32'(held_q) + 32'd1) % N);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            held_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            ptr_q   <= ptr_d;
        end
    end

`ifdef UMI_ARB_STARVE_EN
    // Per-requester wait counters, saturating at the threshold.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!bus.requests[i] || (grants_c[i] && bus.ready)) begin
                cnt_d[i] = '0;
            end else if (!arbmask[i] && !grants_c[i] && cnt_q[i] != CW'(STARVE)) begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif
endmodule

// File: tb/tb_umi_arbiter_sched.sv
// Self-checking bench for umi_arbiter_sched: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_umi_arbiter_sched;
    localparam int unsigned N      = 4;
    localparam int unsigned STARVE = 4;

    logic           clk = 1'b0;
    logic           nreset;
    logic [1:0]     arbmode;
    logic [N-1:0]   arbmask;

    int n_checks = 0;
    int n_fail   = 0;

    umi_arbiter_sched_if #(.N(N)) bus ();

    umi_arbiter_sched #(.N(N), .STARVE(STARVE)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .arbmode (arbmode),
        .arbmask (arbmask),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_locked;
    int m_held;
    int m_ptr;
    int m_cnt [N];

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_locked = 1'b0;
        m_held   = 0;
        m_ptr    = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endfunction

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        logic [N-1:0] el;
        int w;
        g  = '0;
        w  = -1;
        el = bus.requests & ~arbmask;
        if (!nreset) return g;
        if (m_locked) begin
            g[m_held] = bus.requests[m_held];
            return g;
        end
`ifdef UMI_ARB_STARVE_EN
        for (int i = 0; i < N; i++)
            if (w < 0 && el[i] && m_cnt[i] == STARVE) w = i;
`endif
        if (w < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = arbmode[0] ? (m_ptr + k) % N : k;
                if (w < 0 && el[idx]) w = idx;
            end
        end
        if (w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    function automatic void model_edge(input logic [N-1:0] g);
        int w;
        w = -1;
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        for (int i = 0; i < N; i++) begin
            if (!bus.requests[i] || (g[i] && bus.ready)) m_cnt[i] = 0;
            else if (!arbmask[i] && !g[i] && m_cnt[i] < STARVE) m_cnt[i]++;
        end
        if (m_locked) begin
            if (!bus.requests[m_held]) m_locked = 1'b0;
            else if (bus.ready) begin
                m_locked = 1'b0;
                m_ptr    = (m_held + 1) % N;
            end
        end else if (w >= 0) begin
            if (bus.ready) m_ptr = (w + 1) % N;
            else begin
                m_locked = 1'b1;
                m_held   = w;
            end
        end
    endfunction

    // Inputs are set by the caller just after a rising edge; grants checked mid-cycle.
    task automatic do_cycle(input string tag, input bit has_c, input logic [N-1:0] exp_c);
        logic [N-1:0] e;
        #2;
        e = model_grant();
        check(tag, bus.grants, e);
        if (has_c) check({tag, "_const"}, bus.grants, exp_c);
        @(posedge clk);
        model_edge(e);
        #1;
    endtask

    task automatic set_in(input logic [1:0] m, input logic [N-1:0] msk,
                          input logic [N-1:0] rq, input logic rdy);
        arbmode          = m;
        arbmask          = msk;
        bus.requests     = rq;
        bus.ready        = rdy;
    endtask

    task automatic pulse_reset();
        nreset = 1'b0;
        #1;
        check("reset_grants", bus.grants, '0);
        model_reset();
        @(posedge clk);
        #1;
        check("reset_hold", bus.grants, '0);
        nreset = 1'b1;
    endtask

    initial begin
        nreset = 1'b0;
        set_in(2'b00, '0, '0, 1'b0);
        model_reset();
        #1;
        check("por_grants", bus.grants, '0);
        @(posedge clk);
        #1;
        nreset = 1'b1;

        // Fixed priority starves requester 3 behind requester 1
        set_in(2'b00, '0, 4'b1110, 1'b1);
        for (int c = 0; c < 3; c++) do_cycle("fixed_1110", 1'b1, 4'b0010);

        // Round-robin rotation from reset
        pulse_reset();
        set_in(2'b01, '0, 4'b1111, 1'b1);
        do_cycle("rr_0", 1'b1, 4'b0001);
        do_cycle("rr_1", 1'b1, 4'b0010);
        do_cycle("rr_2", 1'b1, 4'b0100);
        do_cycle("rr_3", 1'b1, 4'b1000);
        do_cycle("rr_4", 1'b1, 4'b0001);

        // Stalled sink holds the grant, then pointer moves past the winner
        pulse_reset();
        set_in(2'b01, '0, 4'b0101, 1'b0);
        for (int c = 0; c < 3; c++) do_cycle("lock_stall", 1'b1, 4'b0001);
        bus.ready = 1'b1;
        do_cycle("lock_hs", 1'b1, 4'b0001);
        do_cycle("lock_next", 1'b1, 4'b0100);

        // Lock ignores mask and higher-priority requests
        pulse_reset();
        set_in(2'b00, '0, 4'b0100, 1'b0);
        do_cycle("lk2_enter", 1'b1, 4'b0100);
        set_in(2'b00, 4'b0100, 4'b0111, 1'b0);
        do_cycle("lk2_mask0", 1'b1, 4'b0100);
        do_cycle("lk2_mask1", 1'b1, 4'b0100);
        bus.ready = 1'b1;
        do_cycle("lk2_hs", 1'b1, 4'b0100);
        do_cycle("lk2_after", 1'b1, 4'b0001);

        // Held requester dropping its request releases the lock without a grant
        set_in(2'b01, '0, 4'b0010, 1'b0);
        do_cycle("drop_enter", 1'b0, '0);
        set_in(2'b01, '0, 4'b1000, 1'b0);
        do_cycle("drop_zero", 1'b1, 4'b0000);
        do_cycle("drop_idle", 1'b0, '0);

        // Reset while locked on requester 1
        pulse_reset();
        set_in(2'b00, '0, 4'b0010, 1'b0);
        do_cycle("rst_lock", 1'b1, 4'b0010);
        do_cycle("rst_lock2", 1'b1, 4'b0010);
        pulse_reset();
        set_in(2'b01, '0, 4'b1111, 1'b1);
        do_cycle("rst_after", 1'b1, 4'b0001);

        // Mode 10 behaves as fixed, 11 as round-robin
        set_in(2'b10, '0, 4'b1010, 1'b1);
        do_cycle("mode10", 1'b1, 4'b0010);
        set_in(2'b11, '0, 4'b1010, 1'b1);
        do_cycle("mode11", 1'b1, 4'b1000);

`ifdef UMI_ARB_STARVE_EN
        pulse_reset();
        set_in(2'b00, '0, 4'b1001, 1'b1);
        for (int c = 0; c < 4; c++) do_cycle("starve_wait", 1'b1, 4'b0001);
        do_cycle("starve_win", 1'b1, 4'b1000);
        do_cycle("starve_resume", 1'b1, 4'b0001);
`endif

        // Randomized traffic against the model
        pulse_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] msk;
            msk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            set_in(2'($urandom), msk, N'($urandom), ($urandom_range(0, 2) != 0));
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else do_cycle("rand", 1'b0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/umi_arbiter_sched.md
UMI_ARBITER_SCHED -- requirements
Module: umi_arbiter_sched

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..16).
REQ-002 SHALL have parameter STARVE, default 16, meaning starvation threshold in cycles (1..255), used only when UMI_ARB_STARVE_EN is defined.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port nreset  input  1  asynchronous active-low reset.
REQ-005 SHALL have port arbmode  input  2  00 fixed priority, 01 round-robin, 10 treated as 00, 11 treated as 01.
REQ-006 SHALL have port arbmask  input  N  bit i=1 excludes requester i from new arbitration.
REQ-007 SHALL have port requests  input  N  bit i = requester i UMI valid.
REQ-008 SHALL have port ready  input  1  downstream UMI ready of the shared output.
REQ-009 SHALL have port grants  output  N  one-hot or zero grant vector that selects the mux input.

Function
REQ-010 SHALL drive grants combinationally from requests and internal state: zero-cycle request-to-grant latency.
REQ-011 SHALL keep grants one-hot or all-zero in every cycle; grants SHALL be zero when no eligible request exists.
REQ-012 SHALL define a handshake as grants[i] & requests[i] & ready at a rising clk edge.
REQ-013 Fixed priority: lowest-index unmasked requester SHALL win.
REQ-014 Round-robin: 4-bit-or-wider pointer P; search starts at index P, wraps from N-1 to 0; after a handshake by winner w, P SHALL become (w+1) mod N.
REQ-015 Pointer SHALL NOT change on cycles without a handshake; in fixed-priority mode it SHALL still update on handshakes.
REQ-016 Lock: if grants[i]=1, requests[i]=1 and ready=0 at an edge, the arbiter SHALL enter LOCKED holding i.
REQ-017 In LOCKED, grants SHALL equal the held one-hot vector regardless of arbmask, arbmode, or higher-priority requests.
REQ-018 LOCKED SHALL return to IDLE on the handshake of the held requester; the next arbitration occurs in the following cycle.
REQ-019 If the held requester deasserts requests while LOCKED (protocol violation), grants SHALL fall to zero that cycle and the arbiter SHALL return to IDLE at the next edge without pointer update.
REQ-020 States SHALL be exactly IDLE (combinational arbitration) and LOCKED (held grant).
REQ-021 Changes to arbmode or arbmask SHALL take effect in the same cycle in IDLE only.

Reset
REQ-022 While nreset=0, grants SHALL be all-zero, state SHALL be IDLE, P SHALL be 0, and all starvation counters SHALL be 0.
REQ-023 Reset assertion mid-LOCKED SHALL immediately drop the grant and clear the lock; after deassertion, requester 0 SHALL have highest round-robin priority.

Configuration
REQ-024 Macro UMI_ARB_STARVE_EN SHALL compile in per-requester starvation counters.
REQ-025 With the macro defined, counter i SHALL increment, saturating at STARVE, on each edge where requests[i]=1, arbmask[i]=0 and grants[i]=0, and SHALL clear on requester i handshake or on requests[i]=0.
REQ-026 With the macro defined, in IDLE, any requester whose counter equals STARVE SHALL take absolute priority over arbmode, lowest index first among several.
REQ-027 Without the macro, no counters SHALL exist and arbitration SHALL follow arbmode only.

Verification
REQ-028 arbmode=00, requests=4'b1110, ready=1 for 3 cycles -> grants=4'b0010 each cycle; requester 3 is never granted (starvation disabled).
REQ-029 arbmode=01, requests=4'b1111, ready=1 after reset -> grants sequence 0001,0010,0100,1000,0001.
REQ-030 arbmode=01, requests=4'b0101, ready=0 for 3 cycles then 1 -> grants=0001 for all 4 cycles; next cycle grants=0100.
REQ-031 LOCKED on requester 2, then arbmask=4'b0100 and requests=4'b0111 -> grants stays 0100 until handshake; then grants=0001.
REQ-032 UMI_ARB_STARVE_EN, STARVE=4, arbmode=00, requests=4'b1001, ready=1 -> requester 3 granted on cycle 5 (after 4 denied edges), then requester 0 resumes.
REQ-033 nreset pulsed low while LOCKED on requester 1 with ready=0 -> grants=0 during reset; after release with requests=4'b1111 and arbmode=01 -> grants=0001.
